uart_rx_fifo: RTL and testbench

- Memory-mapped UART receiver (8N1) with a receive FIFO and a level interrupt.
- Sits in the peripheral address region behind the platform's peripheral decode, on the same en/we/addr/data bus style as the CPU data port.
- Its interrupt output drives one PLIC source line.
- Read data is registered, so the platform's registered-enable read mux selects it one cycle after the access.

---
 rtl/uart_rx_fifo.sv | 179 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a byte FIFO, exposed as four 32-bit registers
// on a single-cycle en/we/addr bus with a level interrupt on FIFO fill level.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  input  logic [3:0]  we_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        rx_i,
  output logic        irq_o,
  input  logic        iack_i
);
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FILL_W-1:0] DEPTH    = FILL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic              rx_meta_q, rx_s_q;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        shift_q, shift_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0] count_q, count_d;
  logic              frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic              irq_en_q, irq_en_d, irq_q, irq_d;
  logic [7:0]        thresh_q, thresh_d;
  logic [31:0]       data_q, data_d;
  logic [7:0]        fifo_mem [FIFO_DEPTH];

  logic rx_done, rx_stop_ok;
  logic rd_en, wr_en, pop, push_ok, fifo_full, fifo_empty;
  logic [1:0] reg_sel;

  logic unused_ok;
  assign unused_ok = ^{iack_i, addr_i[1:0], data_i[30:18], data_i[15:8]};

  // Receiver: counts are started on the synchronized falling edge so the
  // START sample lands mid-bit and each later sample one bit period apart.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    rx_done    = 1'b0;
    rx_stop_ok = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_BIT) begin
          cnt_d = '0;
          idx_d = 3'd0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_BIT) begin
          shift_d[idx_q] = rx_s_q;
          cnt_d = '0;
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_BIT) begin
          rx_done    = 1'b1;
          rx_stop_ok = rx_s_q;
          cnt_d      = '0;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_en      = en_i && (we_i == 4'b0000);
  assign wr_en      = en_i && (we_i != 4'b0000);
  assign reg_sel    = addr_i[3:2];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH);
  assign pop        = rd_en && (reg_sel == 2'd0) && !fifo_empty;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push_ok    = rx_done && rx_stop_ok && (!fifo_full || pop);

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop)      count_d = count_q + FILL_W'(1);
    else if (!push_ok && pop) count_d = count_q - FILL_W'(1);

    // Sticky sets take priority over a same-cycle software clear.
    frame_err_d = (rx_done && !rx_stop_ok) ||
                  (frame_err_q && !(wr_en && reg_sel == 2'd1 && data_i[17]));
    overrun_d   = (rx_done && rx_stop_ok && fifo_full && !pop) ||
                  (overrun_q && !(wr_en && reg_sel == 2'd1 && data_i[16]));

    irq_en_d = irq_en_q;
    thresh_d = thresh_q;
    if (wr_en && reg_sel == 2'd2) begin
      irq_en_d = data_i[31];
      thresh_d = (data_i[7:0] == 8'd0) ? 8'd1 : data_i[7:0];
    end
    irq_d = irq_en_d && (32'(count_d) >= 32'(thresh_d));

    data_d = data_q;
    if (rd_en) begin
      case (reg_sel)
        2'd0: data_d = fifo_empty ? 32'h8000_0000 : {24'd0, fifo_mem[rd_ptr_q]};
        2'd1: data_d = {irq_en_q, 13'd0, frame_err_q, overrun_q, thresh_q, 8'(count_q)};
        2'd2: data_d = {irq_en_q, 23'd0, thresh_q};
        2'd3: data_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      shift_q     <= 8'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      irq_en_q    <= 1'b0;
      thresh_q    <= 8'd1;
      irq_q       <= 1'b0;
      data_q      <= 32'd0;
    end else begin
      rx_meta_q   <= rx_i;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      irq_en_q    <= irq_en_d;
      thresh_q    <= thresh_d;
      irq_q       <= irq_d;
      data_q      <= data_d;
    end
  end

  assign data_o = data_q;
  assign irq_o  = irq_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: register-access vector table, directed UART
// corner-case sequences, then random frames checked against a queue model.
module tb_uart_rx_fifo;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  // Push edge after the start edge: 2 sync stages + idle detect, half a bit,
  // then eight data bits and the stop bit one period apart.
  localparam int STOP_EDGE = 3 + CPB / 2 + 9 * CPB;

  logic        clk = 1'b0;
  logic        reset, en_i, rx_i, irq_o, iack_i;
  logic [3:0]  we_i, addr_i;
  logic [31:0] data_i, data_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_do;
    logic        exp_irq;
  } vec_t;
  vec_t vecs [17];

  // Reference model state
  logic [7:0] mq [$];
  logic       m_fe, m_ov, m_ien;
  logic [7:0] m_thr;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .en_i(en_i), .we_i(we_i), .addr_i(addr_i),
    .data_i(data_i), .data_o(data_o), .rx_i(rx_i), .irq_o(irq_o), .iack_i(iack_i)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %-18s 0x%08h", name, act);
    end
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] v);
    en_i = 1'b1; we_i = 4'h0; addr_i = a;
    tick(1);
    en_i = 1'b0;
    v = data_o;
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] we);
    en_i = 1'b1; we_i = we; addr_i = a; data_i = d;
    tick(1);
    en_i = 1'b0; we_i = 4'h0;
  endtask

  // Drives one 8N1 frame; optionally issues a RXDATA read in cycle rd_at.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int rd_at, output logic [31:0] rd_val);
    rd_val = 32'd0;
    for (int c = 0; c < 10 * CPB; c++) begin
      int bi;
      bi = c / CPB;
      if (bi == 0)      rx_i = 1'b0;
      else if (bi <= 8) rx_i = b[bi-1];
      else              rx_i = stop_bit;
      en_i = (c == rd_at); we_i = 4'h0; addr_i = 4'h0;
      tick(1);
      if (c == rd_at) rd_val = data_o;
    end
    en_i = 1'b0;
    rx_i = 1'b1;
  endtask

  function automatic logic [31:0] m_status();
    return {m_ien, 13'd0, m_fe, m_ov, m_thr, 8'(mq.size())};
  endfunction

  function automatic logic m_irq();
    return m_ien && (mq.size() >= int'(m_thr));
  endfunction

  initial begin
    logic [31:0] v, w;
    logic [7:0]  b;
    logic        ok;
    int          nops, kind;

    iack_i = 1'b0; en_i = 1'b0; we_i = 4'h0; addr_i = 4'h0; data_i = 32'd0;
    rx_i = 1'b1; reset = 1'b1;
    tick(3);
    check("rst_data_o", data_o, 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    reset = 1'b0;
    tick(2);

    // Register map on an empty FIFO; writes must leave data_o untouched.
    vecs[0]  = '{4'h0, 4'h0, 32'h0,         32'h8000_0000, 1'b0};
    vecs[1]  = '{4'h0, 4'h4, 32'h0,         32'h0000_0100, 1'b0};
    vecs[2]  = '{4'h0, 4'h8, 32'h0,         32'h0000_0001, 1'b0};
    vecs[3]  = '{4'h0, 4'hC, 32'h0,         32'h0000_0000, 1'b0};
    vecs[4]  = '{4'hF, 4'h8, 32'h8000_0000, 32'h0000_0000, 1'b0};
    vecs[5]  = '{4'h0, 4'h8, 32'h0,         32'h8000_0001, 1'b0};
    vecs[6]  = '{4'h0, 4'h4, 32'h0,         32'h8000_0100, 1'b0};
    vecs[7]  = '{4'h1, 4'h8, 32'h0000_00FF, 32'h8000_0100, 1'b0};
    vecs[8]  = '{4'h0, 4'h8, 32'h0,         32'h0000_00FF, 1'b0};
    vecs[9]  = '{4'hF, 4'hC, 32'hFFFF_FFFF, 32'h0000_00FF, 1'b0};
    vecs[10] = '{4'h0, 4'hC, 32'h0,         32'h0000_0000, 1'b0};
    vecs[11] = '{4'hF, 4'h0, 32'h1234_5678, 32'h0000_0000, 1'b0};
    vecs[12] = '{4'h0, 4'h0, 32'h0,         32'h8000_0000, 1'b0};
    vecs[13] = '{4'h0, 4'h9, 32'h0,         32'h0000_00FF, 1'b0};
    vecs[14] = '{4'h0, 4'h6, 32'h0,         32'h0000_FF00, 1'b0};
    vecs[15] = '{4'h8, 4'h8, 32'h0000_0001, 32'h0000_FF00, 1'b0};
    vecs[16] = '{4'h0, 4'h8, 32'h0,         32'h0000_0001, 1'b0};
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].we != 4'h0) bus_wr(vecs[i].addr, vecs[i].wdata, vecs[i].we);
      else                    bus_rd(vecs[i].addr, v);
      check($sformatf("vec%0d_data", i), data_o, vecs[i].exp_do);
      check($sformatf("vec%0d_irq", i), 32'(irq_o), 32'(vecs[i].exp_irq));
    end

    // Single byte, then empty read.
    send_frame(8'hA5, 1'b1, -1, v);
    bus_rd(4'h0, v); check("a5_read", v, 32'h0000_00A5);
    bus_rd(4'h0, v); check("a5_empty", v, 32'h8000_0000);

    // Short low glitch is a false start; receiver must still take a real frame.
    rx_i = 1'b0; tick(6); rx_i = 1'b1; tick(40);
    bus_rd(4'h4, v); check("glitch_status", v, 32'h0000_0100);
    send_frame(8'h3C, 1'b1, -1, v);
    bus_rd(4'h0, v); check("after_glitch", v, 32'h0000_003C);

    // Overrun on the fifth byte.
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1, -1, v);
    bus_rd(4'h4, v); check("ovr_status", v, 32'h0001_0104);
    for (int k = 1; k <= 4; k++) begin
      bus_rd(4'h0, v); check($sformatf("ovr_read%0d", k), v, 32'(k));
    end
    bus_rd(4'h0, v); check("ovr_empty", v, 32'h8000_0000);
    bus_wr(4'h4, 32'h0001_0000, 4'hF);
    bus_rd(4'h4, v); check("ovr_cleared", v, 32'h0000_0100);

    // Framing error.
    send_frame(8'h77, 1'b0, -1, v);
    tick(CPB);
    bus_rd(4'h4, v); check("ferr_status", v, 32'h0002_0100);
    bus_wr(4'h4, 32'h0002_0000, 4'hF);
    bus_rd(4'h4, v); check("ferr_cleared", v, 32'h0000_0100);

    // Interrupt threshold 2.
    bus_wr(4'h8, 32'h8000_0002, 4'hF);
    send_frame(8'hC1, 1'b1, -1, v);
    check("irq_one_byte", 32'(irq_o), 32'd0);
    send_frame(8'hC2, 1'b1, -1, v);
    check("irq_two_bytes", 32'(irq_o), 32'd1);
    bus_rd(4'h0, v); check("irq_pop_data", v, 32'h0000_00C1);
    check("irq_after_pop", 32'(irq_o), 32'd0);
    bus_rd(4'h0, v); check("irq_drain", v, 32'h0000_00C2);
    bus_wr(4'h8, 32'h0000_0001, 4'hF);

    // Full FIFO: fifth stop sample coincides with a RXDATA pop.
    for (int k = 1; k <= 4; k++) send_frame(8'(17 * k), 1'b1, -1, v);
    send_frame(8'h55, 1'b1, STOP_EDGE - 1, v);
    check("full_pp_data", v, 32'h0000_0011);
    bus_rd(4'h4, v); check("full_pp_status", v, 32'h0000_0104);
    for (int k = 2; k <= 5; k++) begin
      bus_rd(4'h0, v); check($sformatf("full_pp_read%0d", k), v, 32'(17 * k));
    end

    // Reset in the middle of a frame.
    bus_wr(4'h8, 32'h8000_0001, 4'hF);
    send_frame(8'h99, 1'b1, -1, v);
    bus_rd(4'h4, v); check("pre_rst_status", v, 32'h8000_0101);
    check("pre_rst_irq", 32'(irq_o), 32'd1);
    rx_i = 1'b0; tick(40);
    reset = 1'b1; rx_i = 1'b1; tick(1);
    check("midrst_data_o", data_o, 32'd0);
    check("midrst_irq", 32'(irq_o), 32'd0);
    reset = 1'b0; tick(2);
    bus_rd(4'h4, v); check("midrst_status", v, 32'h0000_0100);
    send_frame(8'h5A, 1'b1, -1, v);
    bus_rd(4'h0, v); check("midrst_resync", v, 32'h0000_005A);

    // Random frames and bus operations against the queue model.
    reset = 1'b1; tick(2); reset = 1'b0; tick(2);
    mq.delete(); m_fe = 1'b0; m_ov = 1'b0; m_ien = 1'b0; m_thr = 8'd1;
    for (int f = 0; f < 40; f++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      send_frame(b, ok, -1, v);
      tick(CPB);
      if (!ok)                  m_fe = 1'b1;
      else if (mq.size() < DEPTH) mq.push_back(b);
      else                      m_ov = 1'b1;
      check($sformatf("rnd%0d_irq", f), 32'(irq_o), 32'(m_irq()));
      nops = $urandom_range(0, 3);
      for (int o = 0; o < nops; o++) begin
        kind = $urandom_range(0, 3);
        case (kind)
          0: begin
            bus_rd(4'h0, v);
            if (mq.size() != 0) check($sformatf("rnd%0d_rx", f), v, {24'd0, mq.pop_front()});
            else                check($sformatf("rnd%0d_rx", f), v, 32'h8000_0000);
          end
          1: begin
            w = m_status();
            bus_rd(4'h4, v);
            check($sformatf("rnd%0d_status", f), v, w);
          end
          2: begin
            w = $urandom;
            w[7:0] = 8'($urandom_range(0, 5));
            bus_wr(4'h8, w, 4'hF);
            m_ien = w[31];
            m_thr = (w[7:0] == 8'd0) ? 8'd1 : w[7:0];
          end
          default: begin
            w = $urandom;
            bus_wr(4'h4, w, 4'hF);
            if (w[17]) m_fe = 1'b0;
            if (w[16]) m_ov = 1'b0;
          end
        endcase
        check($sformatf("rnd%0d_op_irq", f), 32'(irq_o), 32'(m_irq()));
      end
    end
    w = m_status();
    bus_rd(4'h4, v); check("rnd_final_status", v, w);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
